word_byte_writer: RTL

Store-side byte sequencer for the 8-bit RISC CPU datapath. Accepts one 16-bit word plus a base address over a valid/ready handshake. Issues two byte writes on the 8-bit memory bus: high byte at addr, then low byte at addr+1. This mirrors the two-cycle high-then-low byte assembly used on instruction fetch, and sits between the accumulator/ALU result path and data memory.

---
 rtl/word_byte_writer_pkg.sv | 36 +++
 rtl/word_byte_writer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/word_byte_writer_pkg.sv
// Shared types and helpers for the word-to-byte store sequencer.
// Byte order is selected by WORD_BYTE_WRITER_LOW_FIRST_EN (undefined: high byte first).
package word_byte_writer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
    localparam logic [1:0] ST_WR_HI_ENC = 2'b01;
    localparam logic [1:0] ST_WR_LO_ENC = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        WR_HI = ST_WR_HI_ENC,
        WR_LO = ST_WR_LO_ENC
    } state_t;

    // Byte driven at the base address.
    function automatic logic [BYTE_W-1:0] first_byte(input logic [WORD_W-1:0] w);
`ifdef WORD_BYTE_WRITER_LOW_FIRST_EN
        return w[BYTE_W-1:0];
`else
        return w[WORD_W-1:BYTE_W];
`endif
    endfunction

    // Byte driven at base address + 1.
    function automatic logic [BYTE_W-1:0] second_byte(input logic [WORD_W-1:0] w);
`ifdef WORD_BYTE_WRITER_LOW_FIRST_EN
        return w[WORD_W-1:BYTE_W];
`else
        return w[BYTE_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/word_byte_writer.sv
// Store-side sequencer: splits one 16-bit word into two byte writes at addr and addr+1.
// Optional little-endian order via WORD_BYTE_WRITER_LOW_FIRST_EN (see package).
module word_byte_writer
    import word_byte_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 13,
    parameter int unsigned WAIT_EN_DEFAULT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_W-1:0]     req_word,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  bus_wait,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [BYTE_W-1:0]     bus_data,
    output logic                  bus_wr,
    output logic                  busy,
    output logic                  done
);

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [BYTE_W-1:0]       bus_data_q, bus_data_d;
    logic                    bus_wr_q, bus_wr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    wait_eff;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    assign wait_eff  = (WAIT_EN_DEFAULT != 0) && bus_wait;
    assign addr_inc  = addr_q + ADDR_WIDTH'(1);
    assign req_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            addr_q     <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_wr_q   <= bus_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // A stalled phase re-drives its byte from the latched word, which equals holding it.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        addr_d     = addr_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_wr_d   = bus_wr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                bus_wr_d = 1'b0;
                busy_d   = 1'b0;
                if (req_valid) begin
                    word_d     = req_word;
                    addr_d     = req_addr;
                    bus_addr_d = req_addr;
                    bus_data_d = first_byte(req_word);
                    bus_wr_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = WR_HI;
                end
            end
            WR_HI: begin
                bus_wr_d = 1'b1;
                busy_d   = 1'b1;
                if (wait_eff) begin
                    bus_addr_d = addr_q;
                    bus_data_d = first_byte(word_q);
                end else begin
                    bus_addr_d = addr_inc;
                    bus_data_d = second_byte(word_q);
                    state_d    = WR_LO;
                end
            end
            WR_LO: begin
                if (wait_eff) begin
                    bus_addr_d = addr_inc;
                    bus_data_d = second_byte(word_q);
                    bus_wr_d   = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    bus_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                bus_addr_d = '0;
                bus_data_d = '0;
                bus_wr_d   = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    assign bus_addr = bus_addr_q;
    assign bus_data = bus_data_q;
    assign bus_wr   = bus_wr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
